// File: rtl/operand_sequencer.sv
// Run-time loadable operand store that presents one NUM_OPS-wide entry at a time to the ALU.
// Step edge to valid takes 2 cycles; free-running mode gives 1 entry per 2 cycles; ops_out holds while ops_ready=0.
module operand_sequencer #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int NUM_OPS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [NUM_OPS*DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]         last_idx,
  input  logic                      step,
  input  logic                      run,
  input  logic                      wrap_en,
  input  logic                      restart,
  output logic [NUM_OPS*DATA_W-1:0] ops_out,
  output logic                      ops_valid,
  input  logic                      ops_ready,
  output logic [ADDR_W-1:0]         index,
  output logic                      done
);

  localparam int ENTRY_W = NUM_OPS * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PRESENT,
    S_DONE
  } state_t;

  logic [ENTRY_W-1:0] mem [DEPTH];
  state_t             state;
  logic               step_prev;
  logic               step_edge_q;
  logic               last_loaded;

  // Memory is never reset so contents survive rst; a same-cycle LOAD sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      step_prev   <= 1'b0;
      step_edge_q <= 1'b0;
      last_loaded <= 1'b0;
      ops_out     <= '0;
      ops_valid   <= 1'b0;
      index       <= '0;
      done        <= 1'b0;
    end else begin
      step_prev <= step;
      // Edges seen outside IDLE are dropped rather than queued.
      step_edge_q <= step & ~step_prev & (state == S_IDLE);

      if (restart) begin
        state       <= S_IDLE;
        index       <= '0;
        done        <= 1'b0;
        ops_valid   <= 1'b0;
        step_edge_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (step_edge_q || run) begin
              state <= S_LOAD;
            end
          end
          S_LOAD: begin
            ops_out     <= mem[index];
            ops_valid   <= 1'b1;
            last_loaded <= (index == last_idx);
            index       <= (index == last_idx) ? '0 : index + ADDR_W'(1);
            state       <= S_PRESENT;
          end
          S_PRESENT: begin
            if (ops_valid && ops_ready) begin
              ops_valid <= 1'b0;
              if (last_loaded && !wrap_en) begin
                state <= S_DONE;
                done  <= 1'b1;
                index <= '0;
              end else if (run) begin
                state <= S_LOAD;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          S_DONE: begin
            done <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed vectors, multi-cycle corner sequences and a randomized run against a transaction-level model.
module tb_operand_sequencer;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int NUM_OPS = 2;
  localparam int EW      = NUM_OPS * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [EW-1:0]     wr_data;
  logic [ADDR_W-1:0] last_idx;
  logic              step;
  logic              run;
  logic              wrap_en;
  logic              restart;
  logic [EW-1:0]     ops_out;
  logic              ops_valid;
  logic              ops_ready;
  logic [ADDR_W-1:0] index;
  logic              done;

  always #5 clk = ~clk;

  operand_sequencer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .NUM_OPS(NUM_OPS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .last_idx (last_idx),
    .step     (step),
    .run      (run),
    .wrap_en  (wrap_en),
    .restart  (restart),
    .ops_out  (ops_out),
    .ops_valid(ops_valid),
    .ops_ready(ops_ready),
    .index    (index),
    .done     (done)
  );

  typedef struct {
    logic [EW-1:0]     exp_ops;
    logic [ADDR_W-1:0] exp_index;
  } vec_t;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [EW-1:0] model_mem [DEPTH];
  int            exp_idx;
  int            mlast;
  bit            mwrap;
  bit            ended;
  int            hs_count;
  vec_t          vt [6];
  logic [EW-1:0] ent [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_entry(input int a, input logic [EW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    exp_idx = 0;
    ended   = 1'b0;
  endtask

  // One step edge, then wait until the entry should be on ops_out.
  task automatic step_present();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
  endtask

  task automatic take();
    ops_ready = 1'b1;
    tick();
    ops_ready = 1'b0;
  endtask

  // Sequencing rule: next index after an accepted entry, or end of sequence.
  task automatic model_accept();
    if (exp_idx == mlast && !mwrap) begin
      ended   = 1'b1;
      exp_idx = 0;
    end else begin
      exp_idx = (exp_idx == mlast) ? 0 : (exp_idx + 1) % DEPTH;
    end
  endtask

  task automatic monitor(input int ncyc, input int ready_pct);
    bit            stall_prev = 1'b0;
    logic [EW-1:0] held = '0;
    int            last_hs = -1;
    for (int c = 0; c < ncyc; c++) begin
      ops_ready = ($urandom_range(99) < ready_pct);
      check("done_track", done, ended);
      if (stall_prev) check("hold_under_backpressure", ops_out, held);
      if (ops_valid && ops_ready) begin
        if (ended) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_handshake_after_done: got handshake at cycle %0d expected none", c);
        end else begin
          check("handshake_data", ops_out, model_mem[exp_idx]);
          if (ready_pct == 100 && last_hs >= 0 && run) check("handshake_gap", c - last_hs, 2);
          last_hs = c;
          hs_count++;
          model_accept();
        end
      end
      stall_prev = ops_valid && !ops_ready;
      held       = ops_out;
      tick();
    end
  endtask

  initial begin
    ent = '{64'h3f800000_40000000, 64'h7f800000_7fc00000, 64'h0, 64'hc6175d4d_c3e42917};
    vt[0] = '{64'h3f800000_40000000, 4'd1};
    vt[1] = '{64'h7f800000_7fc00000, 4'd2};
    vt[2] = '{64'h00000000_00000000, 4'd3};
    vt[3] = '{64'hc6175d4d_c3e42917, 4'd0};
    vt[4] = '{64'h3f800000_40000000, 4'd1};
    vt[5] = '{64'h7f800000_7fc00000, 4'd2};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; last_idx = '0;
    step = 1'b0; run = 1'b0; wrap_en = 1'b1; restart = 1'b0; ops_ready = 1'b0;
    exp_idx = 0; mlast = 0; mwrap = 1'b1; ended = 1'b0; hs_count = 0;

    // Reset state, with writes issued while reset is held.
    tick();
    write_entry(0, 64'h43615eb0_401762b7);
    write_entry(1, 64'hc6175d4d_c3e42917);
    check("rst_ops_out", ops_out, 0);
    check("rst_ops_valid", ops_valid, 0);
    check("rst_index", index, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // Single step: valid exactly two edges after the step edge; held step gives nothing more.
    last_idx = 4'd1; wrap_en = 1'b1;
    step = 1'b1;
    tick();
    check("s1_valid_edge_n", ops_valid, 0);
    tick();
    check("s1_valid_edge_n1", ops_valid, 0);
    tick();
    check("s1_valid_edge_n2", ops_valid, 1);
    check("s1_op_a", ops_out[31:0], 32'h401762b7);
    check("s1_op_b", ops_out[63:32], 32'h43615eb0);
    check("s1_index", index, 1);
    take();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s1_no_second_entry", ops_valid, 0);
    end
    step = 1'b0;

    // Table-driven single stepping with wrap.
    pulse_restart();
    for (int i = 0; i < 4; i++) write_entry(i, ent[i]);
    last_idx = 4'd3; wrap_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step_present();
      check("tbl_valid", ops_valid, 1);
      check("tbl_ops", ops_out, vt[i].exp_ops);
      check("tbl_index", index, vt[i].exp_index);
      take();
      check("tbl_valid_after_take", ops_valid, 0);
    end

    // Free-running with wrap.
    pulse_restart();
    last_idx = 4'd2; mlast = 2; mwrap = 1'b1; wrap_en = 1'b1;
    hs_count = 0;
    run = 1'b1;
    monitor(14, 100);
    run = 1'b0;
    monitor(4, 100);
    check("s2_handshakes", hs_count >= 6, 1);
    check("s2_done_low", done, 0);

    // Free-running without wrap ends in done; run/step then ignored until restart.
    pulse_restart();
    mwrap = 1'b0; wrap_en = 1'b0;
    hs_count = 0;
    run = 1'b1;
    monitor(12, 100);
    check("s3_handshakes", hs_count, 3);
    check("s3_done", done, 1);
    check("s3_valid", ops_valid, 0);
    check("s3_index", index, 0);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; tick(); step = 1'b0; tick();
    end
    check("s3_still_done", done, 1);
    check("s3_still_idle", ops_valid, 0);
    run = 1'b0;
    ops_ready = 1'b0;
    pulse_restart();
    check("s3_restart_done", done, 0);
    check("s3_restart_index", index, 0);
    step_present();
    check("s3_restart_valid", ops_valid, 1);
    check("s3_restart_entry0", ops_out, ent[0]);

    // Backpressure while presenting entry 0; step edges during PRESENT are dropped.
    for (int i = 0; i < 5; i++) begin
      step = ~step;
      tick();
      check("s4_hold_ops", ops_out, ent[0]);
      check("s4_hold_index", index, 1);
      check("s4_hold_valid", ops_valid, 1);
    end
    take();
    step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s4_single_handshake", ops_valid, 0);
    end

    // Reset mid-presentation clears outputs but not memory.
    step_present();
    check("s5_presenting", ops_valid, 1);
    check("s5_entry1", ops_out, ent[1]);
    ops_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ops_ready = 1'b0;
    check("s5_rst_valid", ops_valid, 0);
    check("s5_rst_ops", ops_out, 0);
    check("s5_rst_index", index, 0);
    check("s5_rst_done", done, 0);
    step_present();
    check("s5_entry0_intact", ops_out, ent[0]);
    take();

    // Write colliding with the LOAD of index 3 returns old data.
    pulse_restart();
    last_idx = 4'd3; wrap_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_present();
      take();
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 64'h12345678_9abcdef0;
    tick();
    wr_en = 1'b0;
    model_mem[3] = 64'h12345678_9abcdef0;
    check("s6_valid", ops_valid, 1);
    check("s6_old_data", ops_out, ent[3]);
    take();
    for (int i = 0; i < 4; i++) begin
      step_present();
      if (i == 3) check("s6_new_data", ops_out, 64'h12345678_9abcdef0);
      take();
    end

    // Randomized contents, end points and backpressure.
    for (int it = 0; it < 6; it++) begin
      run = 1'b0;
      ops_ready = 1'b0;
      pulse_restart();
      for (int a = 0; a < DEPTH; a++) write_entry(a, {$urandom, $urandom});
      mlast = $urandom_range(DEPTH - 1);
      last_idx = ADDR_W'(mlast);
      mwrap = (it % 2 == 0);
      wrap_en = mwrap;
      hs_count = 0;
      run = 1'b1;
      monitor(150, 60);
      run = 1'b0;
      monitor(6, 100);
      if (!mwrap) begin
        check("rnd_done", done, 1);
        check("rnd_count", hs_count, mlast + 1);
      end else begin
        check("rnd_enough", hs_count > mlast + 1, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
Name: operand_sequencer

Overview:
Parametrised operand stimulus store for the floating-point ALU. It holds DEPTH entries, each containing NUM_OPS operands of DATA_W bits, and is loadable at run time through a write port. It presents one entry at a time to the ALU over a valid/ready handshake, either single-stepped or free-running, with selectable wrap-around or stop-at-end. It supersedes the fixed 12-entry, 2-operand, edge-triggered loader.

Parameters:
DATA_W, 32, operand width in bits (IEEE-754 single by default).
DEPTH, 16, number of entries; must be a power of 2.
ADDR_W, 4, entry index width; must equal log2(DEPTH).
NUM_OPS, 2, operands per entry. Op 0 = A, op 1 = B, and so on.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  write the full entry at wr_addr this cycle.
wr_addr  in  ADDR_W  entry to write.
wr_data  in  NUM_OPS*DATA_W  entry data; op k is at [k*DATA_W +: DATA_W].
last_idx  in  ADDR_W  index of the last valid entry (end / wrap point).
step  in  1  a rising edge requests one entry.
run  in  1  level input; while high, entries stream back-to-back.
wrap_en  in  1  1: after last_idx, continue from 0. 0: stop and assert done.
restart  in  1  single-cycle pulse: index <= 0, clear done, return to IDLE.
ops_out  out  NUM_OPS*DATA_W  presented operand entry, same packing as wr_data.
ops_valid  out  1  ops_out is valid.
ops_ready  in  1  the ALU accepts ops_out.
index  out  ADDR_W  index of the next entry to be loaded.
done  out  1  sequence ended (wrap_en=0 and entry last_idx accepted).

Behaviour:
- Reset (rst=1 at a clock edge):
  - Outputs: ops_out=0, ops_valid=0, index=0, done=0.
  - Internal: state=IDLE, step_prev=0.
  - Memory contents are NOT cleared.
  - rst overrides every other input, including a transfer mid-handshake.
- step edge: an edge exists when step=1 and step_prev=0. step_prev <= step every cycle.
  - Edges are honoured only in IDLE. Edges arriving in LOAD, PRESENT or DONE are dropped, not queued.
- IDLE:
  - Go to LOAD on a step edge or on run=1.
- LOAD (one cycle):
  - ops_out <= mem[index]; ops_valid <= 1.
  - index <= (index==last_idx) ? 0 : index+1.
  - Go to PRESENT.
  - The block records whether the loaded entry was last_idx.
- PRESENT:
  - ops_out is held stable while ops_valid=1 and ops_ready=0.
  - Handshake: ops_valid=1 and ops_ready=1 sampled at an edge. On handshake, ops_valid <= 0, then:
    - if the entry was last_idx and wrap_en=0: go to DONE, done <= 1, index <= 0.
    - else if run=1: go to LOAD.
    - else: go to IDLE.
- DONE:
  - done stays 1 and the step/run inputs are ignored.
  - Exits only on restart or rst.
- Latency:
  - Step edge sampled at edge N: ops_valid=1 and ops_out valid after edge N+2.
    - Edge N+1: the edge is registered and the FSM enters LOAD.
    - Edge N+2: the LOAD capture.
  - Free-running throughput with ops_ready held at 1: one entry per 2 cycles.
- restart: in any state, index <= 0, done <= 0, ops_valid <= 0, state <= IDLE. ops_out keeps its last value.
- Writes:
  - Accepted in every state, including during reset.
  - A write and a LOAD to the same address in the same cycle: LOAD returns the old data.
  - Writing the entry currently presented does not change ops_out.
- last_idx is sampled at LOAD. Changing it mid-sequence takes effect at the next LOAD.
  - If index > last_idx at LOAD, the index increments until it wraps naturally at DEPTH-1 → 0.
  - The end/done check still compares against last_idx.
- Simultaneous events: rst > restart > handshake/FSM.

Test Plan:
1. Write mem[0]={43615eb0,401762b7} and mem[1]={c6175d4d,c3e42917}, last_idx=1, wrap_en=1, single step pulse → exactly 2 cycles after the edge: ops_out[31:0]=401762b7, ops_out[63:32]=43615eb0, ops_valid=1, index=1. Holding step high produces no second entry.
2. run=1, ops_ready=1, last_idx=2, wrap_en=1, entries 0..2 = {1.0,2.0}, {inf,nan}, {0,0} → accepted sequence 0,1,2,0,1… with a handshake every 2 cycles and done=0 throughout.
3. Same as scenario 2 but wrap_en=0 → after entry 2 is accepted: done=1, ops_valid=0, index=0. Further run/step activity produces nothing. A restart pulse clears done, and the next step presents entry 0.
4. Backpressure: ops_ready=0 for 5 cycles while ops_valid=1 → ops_out and index hold stable and further step edges are dropped. When ops_ready rises, exactly one handshake occurs.
5. rst asserted during PRESENT (ops_valid=1) → next cycle ops_valid=0, ops_out=0, index=0, done=0. A subsequent step re-presents entry 0 with its previously written data intact.
6. wr_en to address 3 in the same cycle as the LOAD of index 3 → old mem[3] is presented. The next pass through index 3 presents the new data.
